scene_ctrl: RTL and testbench
=============================

Name: scene_ctrl

Overview:
Top-level scene sequencer for the game's VGA path. It owns the MENU/SETTING/GAME/OVER state machine and converts raw button levels into one-cycle events. It holds the user configuration (cnt_mode, difficulty) and selects which scene's pixel RAM word drives the display. It sits between the button debouncers and the per-scene display memories, and replaces local toggling inside individual scene blocks.

Parameters:
DIFF_MAX, 3, highest difficulty value; difficulty wraps DIFF_MAX -> 0
OVER_HOLD, 200_000_000, clk cycles the OVER scene is held before auto-return to MENU
ROW0, 40, first ram_addr_y line of the cursor option band (CURSOR_HILITE_EN only)
ROW_H, 16, height in lines of one option band (CURSOR_HILITE_EN only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_start  in  1  debounced level, start/confirm
btn_up  in  1  debounced level, cursor up
btn_down  in  1  debounced level, cursor down
btn_back  in  1  debounced level, back to menu
game_over  in  1  level from game core
ram_addr_y  in  8  current display line (VGA scan)
menu_data  in  16  pixel word from menu memory
setting_data  in  16  pixel word from setting memory
game_data  in  16  pixel word from game memory
over_data  in  16  pixel word from game-over memory
pixel_data  out  16  selected pixel word, registered
scene  out  2  current state encoding
cursor  out  1  current option index in MENU/SETTING
game_en  out  1  high while scene==GAME
game_rst  out  1  one-cycle pulse on entering GAME
cnt_mode  out  1  configuration bit, toggled in SETTING
difficulty  out  2  configuration value 0..DIFF_MAX

Behaviour:
- Edge detect: a register holds each button's previous level. An event is a rising edge: level & ~prev. A held button gives exactly one event.
- States: MENU=0, SETTING=1, GAME=2, OVER=3. Reset -> MENU.
- Reset values: scene=MENU, cursor=0, cnt_mode=0, difficulty=0, game_rst=0, pixel_data=0, over counter=0, prev regs=0.
- up/down events toggle cursor (two options, wrap both ways). Valid in MENU and SETTING only. cursor clears to 0 on every scene change.
- MENU:
  - start with cursor=0 -> GAME; game_rst=1 for exactly the first GAME cycle.
  - start with cursor=1 -> SETTING.
- SETTING:
  - start with cursor=0 toggles cnt_mode.
  - start with cursor=1 increments difficulty, wrapping DIFF_MAX -> 0.
  - back -> MENU.
- GAME:
  - game_over=1 -> OVER.
  - back -> MENU.
  - game_en=1 throughout GAME.
- OVER:
  - Counter increments each cycle.
  - At OVER_HOLD-1, or on a start event -> MENU; counter clears.
- Priority for simultaneous events: game_over > back > start > up > down. Only one action per cycle; lower-priority events that cycle are dropped.
- cnt_mode and difficulty persist across scene changes; only rst clears them.
- pixel_data: registered mux of the current scene's input. 1-cycle latency from the data inputs. On a scene change, the new source appears on the cycle after scene updates.
- rst mid-game: next cycle is MENU with all outputs at reset values. No game_rst pulse is generated.

Optional Feature:
CURSOR_HILITE_EN
- Defined: in MENU/SETTING, when ROW0+cursor*ROW_H <= ram_addr_y < ROW0+(cursor+1)*ROW_H, pixel_data = ~selected word (inverted highlight). Same 1-cycle latency.
- Undefined: pixel_data is the plain mux output; ram_addr_y is unused; ROW0/ROW_H are ignored.

Decomposition:
- Package scene_pkg: scene state encodings, DIFF_MAX default, button index constants.
- One sub-module, btn_edge: parameterised-width rising-edge detector, instantiated once for 4 bits.
- FSM, config registers and pixel mux stay in scene_ctrl.

Test Plan:
- rst, then hold btn_start high 10 cycles -> exactly one transition MENU->GAME; game_rst high 1 cycle; game_en=1; scene=2.
- From MENU press down, start -> scene=1. Press start -> cnt_mode=1. Press down, then start 4 times -> difficulty 1,2,3,0.
- In GAME assert game_over and btn_back in the same cycle -> scene=3, not 0. Then, with OVER_HOLD=8, after 8 cycles -> scene=0.
- Drive menu_data=16'h1111, game_data=16'h2222; transition MENU->GAME -> pixel_data shows 16'h1111, then 16'h2222 one cycle after scene changes.
- cnt_mode=1, difficulty=2, go to GAME and back -> both values retained. Assert rst -> both cleared, scene=0.
- CURSOR_HILITE_EN defined, cursor=1, ram_addr_y=60, menu_data=16'h00FF -> pixel_data=16'hFF00. At ram_addr_y=30 -> 16'h00FF.

Source files
------------

// File: rtl/scene_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
// Shared definitions for the VGA scene sequencer:
//   - scene_e      : scene state encodings (also the value driven on scene_o)
//   - *_DEFAULT    : default parameter values for scene_ctrl
//   - BTN_*        : bit positions of each button in the packed button vector
// -----------------------------------------------------------------------------
package scene_pkg;

  typedef enum logic [1:0] {
    SC_MENU    = 2'd0,
    SC_SETTING = 2'd1,
    SC_GAME    = 2'd2,
    SC_OVER    = 2'd3
  } scene_e;

  localparam int DIFF_MAX_DEFAULT  = 3;
  localparam int OVER_HOLD_DEFAULT = 200_000_000;
  localparam int ROW0_DEFAULT      = 40;
  localparam int ROW_H_DEFAULT     = 16;

  localparam int NUM_BTN   = 4;
  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_BACK  = 3;

endpackage : scene_pkg

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for W debounced button levels. A button held high
// produces exactly one event, on the first cycle it is seen high.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset (clears previous levels)
//   level_i  in   W debounced button levels
//   event_o  out  W one-cycle events (level & ~previous level)
// -----------------------------------------------------------------------------
module btn_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level_i,
  output logic [W-1:0] event_o
);

  logic [W-1:0] prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= level_i;
  end

  assign event_o = level_i & ~prev_q;

endmodule : btn_edge

// File: rtl/scene_ctrl.sv
// -----------------------------------------------------------------------------
// scene_ctrl
// Top-level scene sequencer for the VGA path: MENU/SETTING/GAME/OVER FSM,
// button edge events, user configuration (cnt_mode, difficulty) and a
// registered mux selecting the active scene's pixel word.
//
// Optional build macro: CURSOR_HILITE_EN
//   defined   : in MENU/SETTING the option band under the cursor is shown
//               inverted (lines ROW0+cursor*ROW_H .. +ROW_H-1)
//   undefined : plain mux; ram_addr_y_i, ROW0 and ROW_H have no effect
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   btn_*_i           debounced button levels (start, up, down, back)
//   game_over_i       level from the game core
//   ram_addr_y_i      current display line
//   *_data_i          pixel words from menu/setting/game/over memories
//   pixel_data_o      selected pixel word, one cycle after its source
//   scene_o           current scene (scene_e encoding)
//   cursor_o          option index in MENU/SETTING
//   game_en_o         high while in GAME
//   game_rst_o        one-cycle pulse on the first GAME cycle
//   cnt_mode_o        configuration bit
//   difficulty_o      configuration value 0..DIFF_MAX
// -----------------------------------------------------------------------------
module scene_ctrl
  import scene_pkg::*;
#(
  parameter int DIFF_MAX  = DIFF_MAX_DEFAULT,
  parameter int OVER_HOLD = OVER_HOLD_DEFAULT,
  parameter int ROW0      = ROW0_DEFAULT,
  parameter int ROW_H     = ROW_H_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_back_i,
  input  logic        game_over_i,
  input  logic [7:0]  ram_addr_y_i,
  input  logic [15:0] menu_data_i,
  input  logic [15:0] setting_data_i,
  input  logic [15:0] game_data_i,
  input  logic [15:0] over_data_i,
  output logic [15:0] pixel_data_o,
  output logic [1:0]  scene_o,
  output logic        cursor_o,
  output logic        game_en_o,
  output logic        game_rst_o,
  output logic        cnt_mode_o,
  output logic [1:0]  difficulty_o
);

  localparam int            CW        = (OVER_HOLD > 2) ? $clog2(OVER_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(OVER_HOLD - 1);
  localparam logic [1:0]    DIFF_LAST = 2'(DIFF_MAX);

  // ---------------------------------------------------------------------------
  // Button events
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_ev;

  assign btn_level[BTN_START] = btn_start_i;
  assign btn_level[BTN_UP]    = btn_up_i;
  assign btn_level[BTN_DOWN]  = btn_down_i;
  assign btn_level[BTN_BACK]  = btn_back_i;

  btn_edge #(.W(NUM_BTN)) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (btn_level),
    .event_o (btn_ev)
  );

  logic ev_start, ev_back, ev_move;
  assign ev_start = btn_ev[BTN_START];
  assign ev_back  = btn_ev[BTN_BACK];
  // Two options only, so up and down both just toggle the cursor.
  assign ev_move  = btn_ev[BTN_UP] | btn_ev[BTN_DOWN];

  // ---------------------------------------------------------------------------
  // Scene FSM, configuration and OVER hold counter
  // ---------------------------------------------------------------------------
  scene_e        scene_q;
  logic          cursor_q;
  logic          game_en_q;
  logic          game_rst_q;
  logic          cnt_mode_q;
  logic [1:0]    difficulty_q;
  logic [CW-1:0] over_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scene_q      <= SC_MENU;
      cursor_q     <= 1'b0;
      game_en_q    <= 1'b0;
      game_rst_q   <= 1'b0;
      cnt_mode_q   <= 1'b0;
      difficulty_q <= 2'd0;
      over_cnt_q   <= '0;
    end else begin
      game_rst_q <= 1'b0;
      // Each if/else chain below encodes game_over > back > start > move:
      // the first matching event is the only action taken this cycle.
      unique case (scene_q)
        SC_MENU: begin
          if (ev_start) begin
            cursor_q <= 1'b0;
            if (!cursor_q) begin
              scene_q    <= SC_GAME;
              game_en_q  <= 1'b1;
              game_rst_q <= 1'b1;
            end else begin
              scene_q <= SC_SETTING;
            end
          end else if (ev_move) begin
            cursor_q <= ~cursor_q;
          end
        end

        SC_SETTING: begin
          if (ev_back) begin
            scene_q  <= SC_MENU;
            cursor_q <= 1'b0;
          end else if (ev_start) begin
            if (!cursor_q)                    cnt_mode_q   <= ~cnt_mode_q;
            else if (difficulty_q == DIFF_LAST) difficulty_q <= 2'd0;
            else                              difficulty_q <= difficulty_q + 2'd1;
          end else if (ev_move) begin
            cursor_q <= ~cursor_q;
          end
        end

        SC_GAME: begin
          if (game_over_i) begin
            scene_q    <= SC_OVER;
            game_en_q  <= 1'b0;
            cursor_q   <= 1'b0;
            over_cnt_q <= '0;
          end else if (ev_back) begin
            scene_q   <= SC_MENU;
            game_en_q <= 1'b0;
            cursor_q  <= 1'b0;
          end
        end

        SC_OVER: begin
          if (ev_start || over_cnt_q == HOLD_LAST) begin
            scene_q    <= SC_MENU;
            cursor_q   <= 1'b0;
            over_cnt_q <= '0;
          end else begin
            over_cnt_q <= over_cnt_q + 1'b1;
          end
        end

        default: scene_q <= SC_MENU;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel source mux (registered)
  // ---------------------------------------------------------------------------
  logic [15:0] pixel_sel;
  logic [15:0] pixel_d;
  logic [15:0] pixel_q;

`ifdef CURSOR_HILITE_EN
  logic [15:0] band_lo;
  logic [15:0] band_hi;
  logic        in_band;

  assign band_lo = 16'(ROW0) + (cursor_q ? 16'(ROW_H) : 16'd0);
  assign band_hi = band_lo + 16'(ROW_H);
  assign in_band = ({8'h00, ram_addr_y_i} >= band_lo) &&
                   ({8'h00, ram_addr_y_i} <  band_hi);
`else
  // Highlight disabled: fold the otherwise idle inputs into a dead sink.
  logic [15:0] unused_hilite;
  assign unused_hilite = {8'h00, ram_addr_y_i} ^ 16'(ROW0) ^ 16'(ROW_H);
`endif

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    pixel_sel = menu_data_i;
    unique case (scene_q)
      SC_MENU:    pixel_sel = menu_data_i;
      SC_SETTING: pixel_sel = setting_data_i;
      SC_GAME:    pixel_sel = game_data_i;
      SC_OVER:    pixel_sel = over_data_i;
      default:    pixel_sel = menu_data_i;
    endcase
    pixel_d = pixel_sel;
`ifdef CURSOR_HILITE_EN
    if ((scene_q == SC_MENU || scene_q == SC_SETTING) && in_band)
      pixel_d = ~pixel_sel;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) pixel_q <= 16'h0000;
    else     pixel_q <= pixel_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pixel_data_o = pixel_q;
  assign scene_o      = scene_q;
  assign cursor_o     = cursor_q;
  assign game_en_o    = game_en_q;
  assign game_rst_o   = game_rst_q;
  assign cnt_mode_o   = cnt_mode_q;
  assign difficulty_o = difficulty_q;

endmodule : scene_ctrl

// File: tb/tb_scene_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scene_ctrl
// Table-driven bench for scene_ctrl (OVER_HOLD reduced to 8). Each table row
// gives the inputs for one clock and the expected outputs after that clock;
// expectations are queued when a row is driven and compared after the edge.
// A short hand-written sequence covers the cursor highlight band.
// -----------------------------------------------------------------------------
module tb_scene_ctrl;
  import scene_pkg::*;

  localparam logic [15:0] MENU_W = 16'h1111;
  localparam logic [15:0] SET_W  = 16'h3333;
  localparam logic [15:0] GAME_W = 16'h2222;
  localparam logic [15:0] OVER_W = 16'h4444;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_up, btn_down, btn_back, game_over;
  logic [7:0]  ram_addr_y;
  logic [15:0] menu_data, setting_data, game_data, over_data;
  logic [15:0] pixel_data;
  logic [1:0]  scene;
  logic        cursor, game_en, game_rst, cnt_mode;
  logic [1:0]  difficulty;

  always #5 clk = ~clk;

  scene_ctrl #(.OVER_HOLD(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_i    (btn_start),
    .btn_up_i       (btn_up),
    .btn_down_i     (btn_down),
    .btn_back_i     (btn_back),
    .game_over_i    (game_over),
    .ram_addr_y_i   (ram_addr_y),
    .menu_data_i    (menu_data),
    .setting_data_i (setting_data),
    .game_data_i    (game_data),
    .over_data_i    (over_data),
    .pixel_data_o   (pixel_data),
    .scene_o        (scene),
    .cursor_o       (cursor),
    .game_en_o      (game_en),
    .game_rst_o     (game_rst),
    .cnt_mode_o     (cnt_mode),
    .difficulty_o   (difficulty)
  );

  typedef struct packed {
    logic [1:0] scene;
    logic       cursor;
    logic       cnt_mode;
    logic [1:0] diff;
    logic       en;
    logic       grst;
  } obs_t;

  typedef struct {
    logic rst, start, up, down, back, gover;
    obs_t exp;
  } vec_t;

  typedef struct packed {
    obs_t        obs;
    logic [15:0] pix;
  } exp_t;

  vec_t   vecs[$];
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_err    = 0;
  logic [1:0] model_scene = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, s, u, d, b, g,
                     input logic [1:0] sc, input logic cu, cm,
                     input logic [1:0] df, input logic en, gr);
    vec_t v;
    v.rst = r; v.start = s; v.up = u; v.down = d; v.back = b; v.gover = g;
    v.exp = '{scene: sc, cursor: cu, cnt_mode: cm, diff: df, en: en, grst: gr};
    vecs.push_back(v);
  endtask

  function automatic logic [15:0] src_of(input logic [1:0] sc);
    case (sc)
      2'd0:    return MENU_W;
      2'd1:    return SET_W;
      2'd2:    return GAME_W;
      default: return OVER_W;
    endcase
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    obs_t act;
    rst = v.rst; btn_start = v.start; btn_up = v.up; btn_down = v.down;
    btn_back = v.back; game_over = v.gover;
    // The pixel register samples the scene that was current before this edge.
    e.obs = v.exp;
    e.pix = v.rst ? 16'h0000 : src_of(model_scene);
    model_scene = v.exp.scene;
    exp_q.push_back(e);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    act = '{scene: scene, cursor: cursor, cnt_mode: cnt_mode, diff: difficulty,
            en: game_en, grst: game_rst};
    check($sformatf("row%0d_state", idx), {24'h0, act}, {24'h0, got.obs});
    check($sformatf("row%0d_pixel", idx), {16'h0, pixel_data}, {16'h0, got.pix});
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; btn_start = 0; btn_up = 0; btn_down = 0; btn_back = 0;
    game_over = 0; ram_addr_y = 8'd0;
    menu_data = MENU_W; setting_data = SET_W; game_data = GAME_W; over_data = OVER_W;

    //   rst s u d b g   scene cur cm df en gr
    add(1, 0,0,0,0,0,  2'd0, 0, 0, 2'd0, 0, 0);   // reset state
    add(1, 0,0,0,0,0,  2'd0, 0, 0, 2'd0, 0, 0);
    // Held start: one MENU->GAME transition, one game_rst pulse.
    add(0, 1,0,0,0,0,  2'd2, 0, 0, 2'd0, 1, 1);
    for (int i = 0; i < 9; i++)
      add(0, 1,0,0,0,0, 2'd2, 0, 0, 2'd0, 1, 0);
    add(0, 0,0,0,1,0,  2'd0, 0, 0, 2'd0, 0, 0);   // back -> MENU
    add(0, 0,0,0,0,0,  2'd0, 0, 0, 2'd0, 0, 0);
    add(0, 0,0,1,0,0,  2'd0, 1, 0, 2'd0, 0, 0);   // down -> cursor 1
    add(0, 1,0,0,0,0,  2'd1, 0, 0, 2'd0, 0, 0);   // start -> SETTING
    add(0, 0,0,0,0,0,  2'd1, 0, 0, 2'd0, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 0, 1, 2'd0, 0, 0);   // cnt_mode toggles
    add(0, 0,0,1,0,0,  2'd1, 1, 1, 2'd0, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 1, 1, 2'd1, 0, 0);   // difficulty 1
    add(0, 0,0,0,0,0,  2'd1, 1, 1, 2'd1, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 1, 1, 2'd2, 0, 0);   // 2
    add(0, 0,0,0,0,0,  2'd1, 1, 1, 2'd2, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 1, 1, 2'd3, 0, 0);   // 3
    add(0, 0,0,0,0,0,  2'd1, 1, 1, 2'd3, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 1, 1, 2'd0, 0, 0);   // wraps to 0
    add(0, 0,0,0,0,0,  2'd1, 1, 1, 2'd0, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 1, 1, 2'd1, 0, 0);
    add(0, 0,0,0,0,0,  2'd1, 1, 1, 2'd1, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 1, 1, 2'd2, 0, 0);   // difficulty 2
    add(0, 0,1,0,0,0,  2'd1, 0, 1, 2'd2, 0, 0);   // up wraps 1->0
    add(0, 0,0,0,0,0,  2'd1, 0, 1, 2'd2, 0, 0);
    add(0, 0,1,0,0,0,  2'd1, 1, 1, 2'd2, 0, 0);   // up wraps 0->1
    add(0, 0,0,0,0,0,  2'd1, 1, 1, 2'd2, 0, 0);
    add(0, 0,0,0,1,0,  2'd0, 0, 1, 2'd2, 0, 0);   // back, cursor clears
    add(0, 0,0,0,0,0,  2'd0, 0, 1, 2'd2, 0, 0);
    add(0, 1,0,0,0,0,  2'd2, 0, 1, 2'd2, 1, 1);   // GAME, config kept
    add(0, 0,1,0,0,0,  2'd2, 0, 1, 2'd2, 1, 0);   // up ignored in GAME
    add(0, 0,0,0,1,1,  2'd3, 0, 1, 2'd2, 0, 0);   // game_over beats back
    for (int i = 0; i < 7; i++)
      add(0, 0,0,0,0,0, 2'd3, 0, 1, 2'd2, 0, 0);
    add(0, 0,0,0,0,0,  2'd0, 0, 1, 2'd2, 0, 0);   // 8th cycle -> MENU
    add(0, 0,0,0,0,0,  2'd0, 0, 1, 2'd2, 0, 0);
    add(0, 1,0,0,0,0,  2'd2, 0, 1, 2'd2, 1, 1);
    add(0, 0,0,0,0,0,  2'd2, 0, 1, 2'd2, 1, 0);
    add(0, 0,0,0,0,1,  2'd3, 0, 1, 2'd2, 0, 0);
    add(0, 1,0,0,0,0,  2'd0, 0, 1, 2'd2, 0, 0);   // start leaves OVER early
    add(0, 0,0,0,0,0,  2'd0, 0, 1, 2'd2, 0, 0);
    add(0, 0,0,1,0,0,  2'd0, 1, 1, 2'd2, 0, 0);
    add(0, 1,0,0,0,0,  2'd1, 0, 1, 2'd2, 0, 0);
    add(0, 0,0,0,0,0,  2'd1, 0, 1, 2'd2, 0, 0);
    add(0, 1,0,0,1,0,  2'd0, 0, 1, 2'd2, 0, 0);   // back beats start
    add(0, 0,0,0,0,0,  2'd0, 0, 1, 2'd2, 0, 0);
    add(0, 1,0,0,0,0,  2'd2, 0, 1, 2'd2, 1, 1);
    add(0, 0,0,0,0,0,  2'd2, 0, 1, 2'd2, 1, 0);
    add(1, 0,0,0,0,0,  2'd0, 0, 0, 2'd0, 0, 0);   // rst mid-game
    add(0, 0,0,0,0,0,  2'd0, 0, 0, 2'd0, 0, 0);   // no game_rst pulse

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Highlight band: cursor 1 covers lines 56..71 with the default rows.
    btn_down = 1'b1;
    step();
    check("hilite_cursor", {31'h0, cursor}, 32'h1);
    btn_down = 1'b0;
    menu_data = 16'h00FF;
    ram_addr_y = 8'd60;
    step();
`ifdef CURSOR_HILITE_EN
    check("hilite_y60", {16'h0, pixel_data}, 32'h0000FF00);
`else
    check("hilite_y60", {16'h0, pixel_data}, 32'h000000FF);
`endif
    ram_addr_y = 8'd30;
    step();
    check("hilite_y30", {16'h0, pixel_data}, 32'h000000FF);
    ram_addr_y = 8'd56;
    step();
`ifdef CURSOR_HILITE_EN
    check("hilite_y56", {16'h0, pixel_data}, 32'h0000FF00);
`else
    check("hilite_y56", {16'h0, pixel_data}, 32'h000000FF);
`endif
    ram_addr_y = 8'd72;
    step();
    check("hilite_y72", {16'h0, pixel_data}, 32'h000000FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_scene_ctrl
